// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the ceil-log2 helper used to size pointers.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port storage array, synchronous write and asynchronous read, not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int AW = 3
)(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered status flags and registered or first-word-fall-through read.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0,
  localparam int AW           = clog2(FIFO_DEPTH)
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [AW:0] AF_C = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AE_C = (AW+1)'(AEMPTY_THRESH);
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
  logic wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] head;
  // Acceptance uses pre-edge flags, so a same-cycle read never frees room for a write.
  always_comb begin
    wr_ok     = cs & wr_en & ~full;
    rd_ok     = cs & rd_en & ~empty;
    wr_nxt    = wr_ptr + (AW+1)'(wr_ok);
    rd_nxt    = rd_ptr + (AW+1)'(rd_ok);
    count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) mem (
    .clk     (clk),
    .wr_en   (wr_ok & ~reset),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      count        <= count_nxt;
      empty        <= wr_nxt == rd_nxt;
      full         <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      almost_full  <= count_nxt >= AF_C;
      almost_empty <= count_nxt <= AE_C;
      overflow     <= cs & wr_en & full;
      underflow    <= cs & rd_en & empty;
    end
  end
  if (FWFT != 0) begin : g_fwft
    always_comb begin
      data_out = empty ? '0 : head;
      rd_valid = ~empty;
    end
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        data_out <= '0;
        rd_valid <= 1'b0;
      end else begin
        data_out <= rd_ok ? head : data_out;
        rd_valid <= rd_ok;
      end
    end
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: table-driven, directed and random checks of param_fifo in both read modes against a queue model.
module tb_param_fifo;
  logic clk = 1'b0;
  logic reset, cs, wr_en, rd_en;
  logic [31:0] data_in, dout0, dout1;
  logic rv0, rv1, empty0, empty1, full0, full1, af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [3:0] cnt0, cnt1;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] m_dout0 = '0;
  logic m_rv0 = 0, m_ovf = 0, m_udf = 0;

  typedef struct {
    logic r, c, w, rd;
    logic [31:0] d;
    int cnt;
    logic [31:0] dout;
    logic rv, ovf, udf;
  } vec_t;
  vec_t tbl[19];

  always #5 clk = ~clk;

  param_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(dout0), .rd_valid(rv0), .empty(empty0), .full(full0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  param_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(dout1), .rd_valid(rv1), .empty(empty1), .full(full1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, c, w, rd, input logic [31:0] d);
    bit was_full, was_empty;
    was_full  = q.size() == 8;
    was_empty = q.size() == 0;
    if (r) begin
      q.delete();
      m_dout0 = '0; m_rv0 = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_ovf = c & w & was_full;
      m_udf = c & rd & was_empty;
      m_rv0 = 0;
      if (c & rd & !was_empty) begin
        m_dout0 = q.pop_front();
        m_rv0 = 1;
      end
      if (c & w & !was_full) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count0", cnt0, n);
    chk("count1", cnt1, n);
    chk("empty0", empty0, n == 0);
    chk("empty1", empty1, n == 0);
    chk("full0", full0, n == 8);
    chk("full1", full1, n == 8);
    chk("afull0", af0, n >= 6);
    chk("afull1", af1, n >= 6);
    chk("aempty0", ae0, n <= 1);
    chk("aempty1", ae1, n <= 1);
    chk("ovf0", ovf0, m_ovf);
    chk("ovf1", ovf1, m_ovf);
    chk("udf0", udf0, m_udf);
    chk("udf1", udf1, m_udf);
    chk("dout0", dout0, m_dout0);
    chk("rvalid0", rv0, m_rv0);
    chk("dout1", dout1, n == 0 ? 32'h0 : q[0]);
    chk("rvalid1", rv1, n != 0);
  endtask

  task automatic step(input logic r, c, w, rd, input logic [31:0] d);
    reset = r; cs = c; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    model(r, c, w, rd, d);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1; cs = 0; wr_en = 0; rd_en = 0; data_in = '0;
    tbl[0] = '{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 8; i++) tbl[1+i] = '{0, 1, 1, 0, 32'hA0 + i, i + 1, 32'h0, 0, 0, 0};
    tbl[9] = '{0, 1, 1, 0, 32'hDEADBEEF, 8, 32'h0, 0, 1, 0};
    for (int i = 0; i < 8; i++) tbl[10+i] = '{0, 1, 0, 1, 32'h0, 7 - i, 32'hA0 + i, 1, 0, 0};
    tbl[18] = '{0, 1, 0, 1, 32'h0, 0, 32'hA7, 0, 0, 1};
    // Fill, overflow, drain and underflow from fixed expectations
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), cnt0, tbl[i].cnt);
      chk($sformatf("tbl%0d_empty", i), empty0, tbl[i].cnt == 0);
      chk($sformatf("tbl%0d_full", i), full0, tbl[i].cnt == 8);
      chk($sformatf("tbl%0d_afull", i), af0, tbl[i].cnt >= 6);
      chk($sformatf("tbl%0d_aempty", i), ae0, tbl[i].cnt <= 1);
      chk($sformatf("tbl%0d_dout", i), dout0, tbl[i].dout);
      chk($sformatf("tbl%0d_rvalid", i), rv0, tbl[i].rv);
      chk($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ovf);
      chk($sformatf("tbl%0d_udf", i), udf0, tbl[i].udf);
    end
    // First-word-fall-through on an empty FIFO
    step(0, 1, 1, 0, 32'h11);
    step(0, 1, 0, 0, 32'h0);
    chk("fwft_dout", dout1, 32'h11);
    chk("fwft_rvalid", rv1, 1'b1);
    step(0, 1, 0, 1, 32'h0);
    chk("fwft_empty", empty1, 1'b1);
    chk("fwft_dout_zero", dout1, 32'h0);
    chk("fwft_reg_dout", dout0, 32'h11);
    // Pointer wrap with simultaneous read and write at constant occupancy
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h100 + i);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 1, 32'h200 + i);
      chk("wrap_count", cnt0, 4);
      chk("wrap_dout", dout0, i < 4 ? 32'h100 + i : 32'h200 + i - 4);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 32'h0);
    // Chip select low holds everything
    step(0, 1, 1, 0, 32'h77);
    step(0, 0, 1, 1, 32'h88);
    chk("cs_count", cnt0, 1);
    chk("cs_rvalid", rv0, 1'b0);
    step(0, 0, 0, 1, 32'h0);
    step(0, 1, 0, 1, 32'h0);
    chk("cs_dout", dout0, 32'h77);
    // Reset mid-fill wins over requests and discards contents
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h300 + i);
    chk("midfill_count", cnt0, 5);
    step(1, 1, 1, 1, 32'hFF);
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1'b1);
    chk("rst_aempty", ae0, 1'b1);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    chk("rst_rvalid", rv0, 1'b0);
    step(0, 1, 1, 0, 32'h55);
    step(0, 1, 0, 1, 32'h0);
    chk("post_rst_dout", dout0, 32'h55);
    chk("post_rst_rvalid", rv0, 1'b1);
    // Random traffic with fill-biased and drain-biased phases
    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias = ((k / 200) % 2) ? 75 : 25;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width in bits.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the number of storage words; it must be a power of two and at least 2.
REQ-004 Parameter AFULL_THRESH, default FIFO_DEPTH-2, SHALL set the almost_full level; legal range 1..FIFO_DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 1, SHALL set the almost_empty level; legal range 0..FIFO_DEPTH-1.
REQ-006 Parameter FWFT, default 0, SHALL select the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007 Ports SHALL be as follows (AW = log2(FIFO_DEPTH)):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cs  in  1  chip select; gates all requests
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  data_out carries a valid read word
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  AW+1  current occupancy
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

Function
REQ-008 A write SHALL be accepted on a clk edge iff cs & wr_en & !full, storing data_in at the write pointer.
REQ-009 A read SHALL be accepted on a clk edge iff cs & rd_en & !empty, advancing the read pointer.
REQ-010 Full and empty SHALL be evaluated from the registered state before the edge; a simultaneous read does not free a slot for a write in the same cycle.
REQ-011 Simultaneous accepted read and write SHALL leave count unchanged, advance both pointers, and leave empty and full unchanged.
REQ-012 Pointers SHALL be AW+1 bits wide and wrap modulo 2*FIFO_DEPTH; full is asserted when the addresses are equal and the MSBs differ.
REQ-013 count, empty, full, almost_full and almost_empty SHALL be registered and SHALL reflect the state after each edge, with no lag.
REQ-014 When FWFT=0, an accepted read SHALL load data_out with the head word and assert rd_valid in the next cycle (1-cycle latency); otherwise data_out SHALL hold its value and rd_valid SHALL be 0.
REQ-015 When FWFT=1, data_out SHALL present the head word combinationally whenever !empty, with rd_valid = !empty; an accepted read pops the word; when empty, data_out SHALL be all zeros.
REQ-016 When FWFT=1 and the FIFO is empty, a written word SHALL appear on data_out one cycle after the write edge.
REQ-017 overflow SHALL pulse high for one cycle after an edge where cs & wr_en & full.
REQ-018 underflow SHALL pulse high for one cycle after an edge where cs & rd_en & empty.
REQ-019 With cs=0, requests SHALL be ignored, state SHALL be held, and overflow/underflow SHALL stay 0.
REQ-020 Rejected requests SHALL NOT alter memory, pointers or count.

Reset
REQ-021 While reset=1 at an edge, the block SHALL clear pointers and count to 0, and drive empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0 and data_out=0.
REQ-022 Reset SHALL take priority over any simultaneous request, and reset mid-operation SHALL discard all contents.
REQ-023 Memory contents SHALL NOT be reset.

Structure
REQ-024 Package fifo_pkg SHALL hold the default DATA_WIDTH/FIFO_DEPTH constants and the ceil-log2 function used for AW.
REQ-025 Storage SHALL be a sub-module fifo_mem: a dual-port array with synchronous write and asynchronous read, instantiated once.

Verification
REQ-026 Verification SHALL cover the following directed scenarios, each at DEPTH=8, WIDTH=32, AF=6, AE=1:
- Fill: write 0xA0..0xA7. almost_empty deasserts at count=2, almost_full asserts at count=6, full asserts at count=8.
- Overflow: write 0xDEADBEEF when full. overflow pulses once, count stays 8, and the later read order is unchanged.
- Drain, FWFT=0: read 8 words. data_out = 0xA0..0xA7 each with 1-cycle latency and rd_valid; then one extra read gives underflow=1 and data_out holds 0xA7.
- FWFT=1: write 0x11. data_out=0x11 and rd_valid=1 the next cycle with no read; read, then empty=1 and data_out=0.
- Wrap: with 4 words stored, run 20 cycles of simultaneous read+write of incrementing data. count stays 4, output order is correct, and pointers wrap.
- Reset mid-fill at count=5. All outputs return to their reset values; a subsequent write of 0x55 followed by a read returns 0x55.
